// File: rtl/led_bank_pkg.sv
// Shared mode/config types and small helpers for the LED bank controller.
package led_bank_pkg;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_PWM     = 3'd3,
        MODE_BREATHE = 3'd4
    } led_mode_e;

    typedef struct packed {
        led_mode_e   mode;
        logic [15:0] period;
    } led_cfg_t;

    localparam logic [15:0] PERIOD_MIN = 16'd1;

    // Unassigned encodings 5-7 collapse to OFF so they can never light a channel.
    function automatic led_mode_e decode_mode(input logic [2:0] raw);
        led_mode_e m;
        case (raw)
            3'd1:    m = MODE_ON;
            3'd2:    m = MODE_BLINK;
            3'd3:    m = MODE_PWM;
            3'd4:    m = MODE_BREATHE;
            default: m = MODE_OFF;
        endcase
        return m;
    endfunction

    function automatic logic [15:0] eff_period(input logic [15:0] period);
        return (period == 16'd0) ? PERIOD_MIN : period;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Time-base prescaler: one-cycle tick once every CLK_HZ/TICK_HZ clocks.
module led_tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // tick_q is high exactly while cnt_q holds the wrap value
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        tick_d = (cnt_d == LAST);
    end

    // prescaler state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= {CNT_W{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_bank_ctrl.sv
// Multi-channel LED controller: OFF/ON/BLINK/PWM/BREATHE per channel,
// configured through a valid/ready write port that accepts at most every other cycle.
module led_bank_ctrl
    import led_bank_pkg::*;
#(
    parameter int  N_LEDS     = 6,
    parameter int  CLK_HZ     = 100_000_000,
    parameter int  TICK_HZ    = 1000,
    parameter int  PWM_BITS   = 8,
    parameter int  ACTIVE_LOW = 0,
    localparam int CH_W       = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic                clkusr_100m,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [2:0]          cfg_mode,
    input  logic [15:0]         cfg_period,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic                cfg_err,
    output logic [N_LEDS-1:0]   led
);
    localparam logic [N_LEDS-1:0]   LED_IDLE  = (ACTIVE_LOW != 0) ? {N_LEDS{1'b1}} : {N_LEDS{1'b0}};
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LEVEL_MIN = {PWM_BITS{1'b0}};

    logic                tick_s;
    logic                accept_s;
    logic                cfg_ready_q, cfg_ready_d;
    logic                cfg_err_q, cfg_err_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N_LEDS-1:0]   on_s;
    logic [N_LEDS-1:0]   led_q, led_d;

    led_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_gen (
        .clk (clkusr_100m),
        .rst (rst),
        .tick(tick_s)
    );

    // handshake, shared PWM counter and output polarity
    always_comb begin
        accept_s    = cfg_valid && cfg_ready_q;
        cfg_ready_d = !accept_s;
        cfg_err_d   = accept_s && (32'(cfg_ch) >= 32'(N_LEDS));
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        led_d       = on_s ^ LED_IDLE;
    end

    // shared registers; ready stays low through reset and rises on the first edge after it
    always_ff @(posedge clkusr_100m or posedge rst) begin
        if (rst) begin
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            pwm_cnt_q   <= {PWM_BITS{1'b0}};
            led_q       <= LED_IDLE;
        end else begin
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_q       <= led_d;
        end
    end

    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_ch
        led_cfg_t            cfg_q, cfg_d;
        logic [PWM_BITS-1:0] duty_q, duty_d;
        logic [PWM_BITS-1:0] level_q, level_d;
        logic [15:0]         tcnt_q, tcnt_d;
        logic                phase_q, phase_d;
        logic                dir_up_q, dir_up_d;
        logic                wr_s, wrap_s, on_b;

        // channel next state; a write beats a coincident tick
        always_comb begin
            cfg_d    = cfg_q;
            duty_d   = duty_q;
            level_d  = level_q;
            tcnt_d   = tcnt_q;
            phase_d  = phase_q;
            dir_up_d = dir_up_q;
            wr_s     = accept_s && (32'(cfg_ch) == 32'(gi));
            wrap_s   = (tcnt_q >= eff_period(cfg_q.period) - 16'd1);
            if (wr_s) begin
                cfg_d.mode   = decode_mode(cfg_mode);
                cfg_d.period = cfg_period;
                duty_d       = cfg_duty;
                level_d      = LEVEL_MIN;
                tcnt_d       = 16'd0;
                phase_d      = 1'b1;
                dir_up_d     = 1'b1;
            end else if (tick_s && (cfg_q.mode == MODE_BLINK || cfg_q.mode == MODE_BREATHE)) begin
                if (wrap_s) begin
                    tcnt_d  = 16'd0;
                    phase_d = !phase_q;
                    if (cfg_q.mode != MODE_BREATHE) begin
                        level_d = level_q;
                    end else if (dir_up_q) begin
                        level_d  = level_q + 1'b1;
                        dir_up_d = (level_d != LEVEL_MAX);
                    end else begin
                        level_d  = level_q - 1'b1;
                        dir_up_d = (level_d == LEVEL_MIN);
                    end
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end else begin
                tcnt_d = tcnt_q;
            end

            case (cfg_q.mode)
                MODE_ON:      on_b = 1'b1;
                MODE_BLINK:   on_b = phase_q;
                MODE_PWM:     on_b = (pwm_cnt_q < duty_q);
                MODE_BREATHE: on_b = (pwm_cnt_q < level_q);
                default:      on_b = 1'b0;
            endcase
        end

        // channel state register
        always_ff @(posedge clkusr_100m or posedge rst) begin
            if (rst) begin
                cfg_q    <= '{mode: MODE_OFF, period: 16'd0};
                duty_q   <= {PWM_BITS{1'b0}};
                level_q  <= {PWM_BITS{1'b0}};
                tcnt_q   <= 16'd0;
                phase_q  <= 1'b0;
                dir_up_q <= 1'b0;
            end else begin
                cfg_q    <= cfg_d;
                duty_q   <= duty_d;
                level_q  <= level_d;
                tcnt_q   <= tcnt_d;
                phase_q  <= phase_d;
                dir_up_q <= dir_up_d;
            end
        end

        assign on_s[gi] = on_b;
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign led       = led_q;

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Bench for led_bank_ctrl: closed-form timing model for a 4-channel build,
// plus an ACTIVE_LOW 5-channel build for polarity, bad-channel and handshake cases.
module tb_led_bank_ctrl;
    localparam int NL   = 4;
    localparam int DIVC = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, a_err;
    logic [1:0]  a_ch;
    logic [2:0]  a_mode;
    logic [15:0] a_period;
    logic [3:0]  a_duty;
    logic [3:0]  a_led;
    logic        b_valid, b_ready, b_err;
    logic [2:0]  b_ch;
    logic [2:0]  b_mode;
    logic [15:0] b_period;
    logic [3:0]  b_duty;
    logic [4:0]  b_led;

    int checks = 0;
    int errors = 0;
    int ecnt;
    int last_acc;
    int m_mode[NL], m_per[NL], m_duty[NL], m_w[NL];
    int p_mode[NL], p_per[NL], p_duty[NL], p_w[NL];

    typedef struct {
        int mode;
        int duty;
        int exp_hi;
    } pwm_vec_t;
    pwm_vec_t vt[8];

    led_bank_ctrl #(.N_LEDS(4), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(4), .ACTIVE_LOW(0)) dut_a (
        .clkusr_100m(clk), .rst(rst), .cfg_valid(a_valid), .cfg_ready(a_ready), .cfg_ch(a_ch),
        .cfg_mode(a_mode), .cfg_period(a_period), .cfg_duty(a_duty), .cfg_err(a_err), .led(a_led));

    led_bank_ctrl #(.N_LEDS(5), .CLK_HZ(1000), .TICK_HZ(100), .PWM_BITS(4), .ACTIVE_LOW(1)) dut_b (
        .clkusr_100m(clk), .rst(rst), .cfg_valid(b_valid), .cfg_ready(b_ready), .cfg_ch(b_ch),
        .cfg_mode(b_mode), .cfg_period(b_period), .cfg_duty(b_duty), .cfg_err(b_err), .led(b_led));

    always #5 clk = ~clk;

    // clock edges since the last reset release
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected LEDs from channel state after edge k: ticks land on edges that are
    // multiples of DIVC, the write edge's own tick is dropped, pwm counter = k mod 16.
    function automatic logic [3:0] model_led(input int k);
        logic [3:0] r = 4'b0000;
        for (int c = 0; c < NL; c++) begin
            int md, pr, dt, w, n, s, lvl, pw;
            bit on;
            if (k >= m_w[c]) begin
                md = m_mode[c]; pr = m_per[c]; dt = m_duty[c]; w = m_w[c];
            end else begin
                md = p_mode[c]; pr = p_per[c]; dt = p_duty[c]; w = p_w[c];
            end
            if (pr == 0) pr = 1;
            n  = k / DIVC - w / DIVC;
            pw = k % 16;
            case (md)
                1:       on = 1'b1;
                2:       on = ((n / pr) % 2) == 0;
                3:       on = pw < dt;
                4: begin
                    s   = (n / pr) % 30;
                    lvl = (s <= 15) ? s : 30 - s;
                    on  = pw < lvl;
                end
                default: on = 1'b0;
            endcase
            r[c] = on;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) chk("led_a_in_reset", a_led, 4'b0000);
        else     chk("led_a_model", a_led, model_led(ecnt - 1));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_model();
        for (int c = 0; c < NL; c++) begin
            m_mode[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_w[c] = 0;
            p_mode[c] = 0; p_per[c] = 0; p_duty[c] = 0; p_w[c] = 0;
        end
        last_acc = -10;
    endtask

    // single write on DUT A; align=1 makes the accept edge coincide with a tick
    task automatic write_a(input int ch, input int mode, input int per, input int duty, input bit align);
        @(negedge clk);
        if (last_acc == ecnt) @(negedge clk);
        while (align && (ecnt % DIVC) != DIVC - 1) @(negedge clk);
        chk("ready_before_write", a_ready, 1);
        a_ch = 2'(ch); a_mode = 3'(mode); a_period = 16'(per); a_duty = 4'(duty);
        a_valid = 1'b1;
        @(posedge clk);
        #1;
        p_mode[ch] = m_mode[ch]; p_per[ch] = m_per[ch]; p_duty[ch] = m_duty[ch]; p_w[ch] = m_w[ch];
        m_mode[ch] = mode; m_per[ch] = per; m_duty[ch] = duty; m_w[ch] = ecnt;
        last_acc = ecnt;
        a_valid  = 1'b0;
    endtask

    initial begin
        int hi;
        rst = 1'b1;
        a_valid = 1'b0; a_ch = 2'd0; a_mode = 3'd0; a_period = 16'd0; a_duty = 4'd0;
        b_valid = 1'b0; b_ch = 3'd0; b_mode = 3'd0; b_period = 16'd0; b_duty = 4'd0;
        clear_model();
        vt[0] = '{3, 4, 4};  vt[1] = '{3, 0, 0};  vt[2] = '{3, 15, 15}; vt[3] = '{3, 1, 1};
        vt[4] = '{1, 0, 16}; vt[5] = '{0, 9, 0};  vt[6] = '{5, 9, 0};   vt[7] = '{7, 9, 0};

        repeat (3) @(negedge clk);
        chk("rst_ready_a", a_ready, 0);
        chk("rst_ready_b", b_ready, 0);
        chk("rst_err_a", a_err, 0);
        chk("rst_led_b", b_led, 5'b11111);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_rise_a", a_ready, 1);
        chk("ready_rise_b", b_ready, 1);
        chk("led_a_release", a_led, 4'b0000);
        chk("led_b_release", b_led, 5'b11111);

        // PWM duty / ON / OFF / unused modes on channel 2
        foreach (vt[i]) begin
            write_a(2, vt[i].mode, 1, vt[i].duty, 1'b0);
            cyc(2);
            hi = 0;
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                hi += int'(a_led[2]);
            end
            chk($sformatf("pwm_high_count_%0d", i), hi, vt[i].exp_hi);
        end

        // blink period 3: 30 on / 30 off
        write_a(1, 2, 3, 0, 1'b0);
        cyc(3);
        hi = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            hi += int'(a_led[1]);
        end
        chk("blink_p3_high_60", hi, 30);

        // period 0 acts as 1
        write_a(0, 2, 0, 0, 1'b0);
        cyc(3);
        hi = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            hi += int'(a_led[0]);
        end
        chk("blink_p0_high_20", hi, 10);

        // write on a tick edge: that tick is not applied, so the first 10 clocks stay on
        write_a(0, 2, 1, 0, 1'b1);
        cyc(1);
        hi = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            hi += int'(a_led[0]);
        end
        chk("write_beats_tick", hi, 10);

        // breathe over more than a full 0..15..0 cycle
        write_a(3, 4, 1, 0, 1'b0);
        cyc(320);

        // random configurations against the model
        for (int r = 0; r < 25; r++) begin
            write_a(int'($urandom_range(3, 0)), int'($urandom_range(7, 0)), int'($urandom_range(4, 0)),
                    int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
            cyc(int'($urandom_range(150, 5)));
        end

        // DUT B: write becomes visible one edge after the accept edge
        @(negedge clk);
        b_ch = 3'd0; b_mode = 3'd1; b_period = 16'd1; b_duty = 4'd0; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        chk("b_ready_after_accept", b_ready, 0);
        chk("b_led_not_yet", b_led, 5'b11111);
        @(negedge clk);
        chk("b_led_on", b_led, 5'b11110);
        chk("b_ready_back", b_ready, 1);

        // bad channel: error pulse, no state change
        @(negedge clk);
        b_ch = 3'd5; b_mode = 3'd0; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        chk("b_err_pulse", b_err, 1);
        @(negedge clk);
        chk("b_err_clear", b_err, 0);
        chk("b_led_kept", b_led, 5'b11110);

        // held valid: every second edge accepted
        @(negedge clk);
        b_ch = 3'd6; b_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_%0d", i), b_ready, (i % 2 == 0) ? 0 : 1);
            chk($sformatf("b2b_err_%0d", i), b_err, (i % 2 == 0) ? 1 : 0);
        end
        b_valid = 1'b0;
        cyc(2);
        chk("b_led_after_b2b", b_led, 5'b11110);

        // reset in the middle of a blink
        write_a(1, 2, 3, 0, 1'b0);
        cyc(5);
        chk("blink_on_before_rst", a_led[1], 1);
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        chk("led_a_async_rst", a_led, 4'b0000);
        chk("led_b_async_rst", b_led, 5'b11111);
        cyc(3);
        rst = 1'b0;
        cyc(80);
        chk("ch1_off_after_rst", a_led, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_bank_ctrl.md
LED_BANK_CTRL -- requirements
Module: led_bank_ctrl

Interface
REQ-001 SHALL have parameter N_LEDS, default 6, number of LED channels (1..32).
REQ-002 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency.
REQ-003 SHALL have parameter TICK_HZ, default 1000, time-base tick rate; CLK_HZ/TICK_HZ >= 2.
REQ-004 SHALL have parameter PWM_BITS, default 8, PWM/duty resolution.
REQ-005 SHALL have parameter ACTIVE_LOW, default 0; 1 inverts every led output.
REQ-006 SHALL have port clkusr_100m  in  1  single clock, rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port cfg_valid  in  1  config write request.
REQ-009 SHALL have port cfg_ready  out  1  block can accept a config write.
REQ-010 SHALL have port cfg_ch  in  max(1,$clog2(N_LEDS))  target channel.
REQ-011 SHALL have port cfg_mode  in  3  channel mode.
REQ-012 SHALL have port cfg_period  in  16  period in ticks (blink half-period / breathe step).
REQ-013 SHALL have port cfg_duty  in  PWM_BITS  PWM duty.
REQ-014 SHALL have port cfg_err  out  1  one-cycle pulse: accepted write had cfg_ch >= N_LEDS.
REQ-015 SHALL have port led  out  N_LEDS  registered LED drive.

Function
REQ-016 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 and emit a one-cycle tick on the wrap cycle.
REQ-017 A free-running PWM_BITS counter SHALL increment every clock; pwm(d) = (counter < d), so d=0 is never on and d=2^PWM_BITS-1 is on for all but one count.
REQ-018 A write SHALL be accepted on a clock edge where cfg_valid && cfg_ready.
REQ-019 cfg_ready SHALL be low the cycle after any accept and high otherwise (outside reset).
REQ-020 On accept with valid cfg_ch, the channel SHALL latch mode/period/duty and clear its tick counter, phase (=on) and breathe level (=0, direction up).
REQ-021 Accept with cfg_ch >= N_LEDS SHALL change no state and pulse cfg_err on the next cycle.
REQ-022 Modes: 0 OFF (inactive), 1 ON (active), 2 BLINK, 3 PWM (pwm(duty)), 4 BREATHE; 5-7 SHALL behave as OFF.
REQ-023 BLINK: on each tick the channel counter SHALL increment; at period-1 it SHALL clear and toggle phase; led active when phase=on.
REQ-024 BREATHE: every period ticks the level SHALL step +-1, reversing at 2^PWM_BITS-1 and at 0; led = pwm(level); cfg_duty unused.
REQ-025 cfg_period = 0 SHALL behave as 1.
REQ-026 led SHALL be registered: a write accepted at edge N is visible on led after edge N+1.
REQ-027 A write coinciding with a tick SHALL take priority; the tick is not applied to that channel.
REQ-028 Tick counter SHALL never exceed 16 bits; no wrap-through beyond period-1.

Reset
REQ-029 While rst high: all channels OFF, counters/phase/level 0, cfg_ready 0, cfg_err 0, led all inactive (all 1 if ACTIVE_LOW).
REQ-030 cfg_ready SHALL rise on the first edge after rst deasserts; rst mid-blink/breathe SHALL abort immediately to reset state.

Structure
REQ-031 Mode enum (OFF, ON, BLINK, PWM, BREATHE) and config-struct typedef SHALL live in package led_bank_pkg.
REQ-032 Prescaler SHALL be a sub-module led_tick_gen (params CLK_HZ, TICK_HZ; out tick); channels are a generate loop.

Verification (CLK_HZ=1000, TICK_HZ=100, N_LEDS=4, PWM_BITS=4)
REQ-033 Reset release -> led=4'b0000, cfg_ready=1 one cycle later; ACTIVE_LOW=1 build -> led=4'b1111.
REQ-034 Write ch1 BLINK period=3 -> led[1] on 30 clocks, off 30 clocks, repeating; other LEDs off.
REQ-035 Write ch2 PWM duty=4 -> led[2] high exactly 4 of every 16 clocks; duty=0 -> never high.
REQ-036 Write ch3 BREATHE period=1 -> level 0..15..0 over 30 ticks (300 clocks); high-count per 16 clocks tracks level.
REQ-037 Write cfg_ch=5 -> cfg_err one-cycle pulse, led unchanged; back-to-back cfg_valid -> every second cycle accepted.
REQ-038 rst asserted mid-BLINK -> led inactive within the same cycle; after release, ch1 stays OFF.
